// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the multi-digit BCD up/down counter:
//   state_t        control FSM states (IDLE, RUN, PAUSED)
//   BCD_MAX_DIGIT  largest legal decimal digit
//   clamp_digit()  forces an out-of-range nibble (A..F) to 9
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter. Purely combinational.
// Ports:
//   digit       current digit value
//   inc / dec   step direction (at most one high)
//   cin         carry (up) or borrow (down) from the lower decade; digit 0
//               gets a constant 1 so that it steps every time
//   digit_next  digit after the step
//   cout        carry/borrow to the next decade (9->0 up, 0->9 down)
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  output logic [3:0] digit_next,
  output logic       cout
);

  always_comb begin
    digit_next = digit;
    cout       = 1'b0;
    if (cin) begin
      if (inc) begin
        // >= rather than == so a stray non-BCD value still rolls to 0
        if (digit >= BCD_MAX_DIGIT) begin
          digit_next = 4'd0;
          cout       = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else if (dec) begin
        if (digit == 4'd0) begin
          digit_next = BCD_MAX_DIGIT;
          cout       = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// DIGITS-decade BCD up/down counter with IDLE/RUN/PAUSED control FSM,
// parallel load (per-digit clamp to 9), synchronous clear and a registered
// one-cycle terminal-count pulse.
// Parameters:
//   DIGITS  number of decades (count is 4*DIGITS bits, digit 0 in [3:0])
//   WRAP    1: wrap at terminal and keep running; 0: hold at terminal, go IDLE
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   clr       synchronous clear (0 when counting up, all 9 when down)
//   load      synchronous load of load_val
//   load_val  BCD load value
//   start     enter/resume RUN
//   stop      pause RUN
//   up_down   1 = up, 0 = down
//   tick      (only with BCD_CNT_TICK_EN) step enable inside RUN
//   count     current BCD count
//   running   FSM is in RUN
//   tc        one-cycle pulse after a terminal-count step
// Optional macro: BCD_CNT_TICK_EN adds the tick input.
// -----------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  up_down,
`ifdef BCD_CNT_TICK_EN
  input  logic                  tick,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  tc
);

  localparam int W = 4 * DIGITS;

  state_t         state_reg, state_next;
  logic [W-1:0]   count_reg, count_next;
  logic           tc_reg, tc_next;

  logic [W-1:0]   stepped;
  logic [W-1:0]   clamped;
  logic [W-1:0]   clear_val;
  logic [DIGITS:0] carry;
  logic           step_en;

`ifdef BCD_CNT_TICK_EN
  assign step_en = tick;
`else
  assign step_en = 1'b1;
`endif

  // Digit 0 always steps; a carry/borrow out of the top decade means every
  // digit was at its terminal value, i.e. the count was at terminal.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .digit      (count_reg[4*gi +: 4]),
        .inc        (up_down),
        .dec        (~up_down),
        .cin        (carry[gi]),
        .digit_next (stepped[4*gi +: 4]),
        .cout       (carry[gi+1])
      );
      assign clamped[4*gi +: 4]   = clamp_digit(load_val[4*gi +: 4]);
      assign clear_val[4*gi +: 4] = up_down ? 4'd0 : BCD_MAX_DIGIT;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tc_next    = 1'b0;
    if (clr) begin
      count_next = clear_val;
      state_next = IDLE;
    end else if (load) begin
      count_next = clamped;
      state_next = IDLE;
    end else if (stop) begin
      if (state_reg == RUN) state_next = PAUSED;
    end else if (start && (state_reg != RUN)) begin
      // Entering RUN: first step happens on the following edge
      state_next = RUN;
    end else if ((state_reg == RUN) && step_en) begin
      if (carry[DIGITS]) begin
        tc_next = 1'b1;
        if (WRAP) count_next = stepped;   // stepped already holds the wrapped value
        else      state_next = IDLE;      // saturate: hold terminal count
      end else begin
        count_next = stepped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign count   = count_reg;
  assign running = (state_reg == RUN);
  assign tc      = tc_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Three counters share one stimulus stream: A (2 digits, wrap), B (2 digits,
// saturate), C (4 digits, wrap). Each is compared every cycle against an
// integer-valued reference model of the counter's rules.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst, clr, load, start, stop, up_down, tick;
  logic [15:0] load_val;

  logic [7:0]  cnt_a, cnt_b;
  logic [15:0] cnt_c;
  logic        run_a, run_b, run_c;
  logic        tc_a, tc_b, tc_c;

  always #5 clk = ~clk;

`ifdef BCD_CNT_TICK_EN
  localparam bit HAS_TICK = 1'b1;
`else
  localparam bit HAS_TICK = 1'b0;
`endif

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .start(start), .stop(stop), .up_down(up_down),
`ifdef BCD_CNT_TICK_EN
    .tick(tick),
`endif
    .count(cnt_a), .running(run_a), .tc(tc_a)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .start(start), .stop(stop), .up_down(up_down),
`ifdef BCD_CNT_TICK_EN
    .tick(tick),
`endif
    .count(cnt_b), .running(run_b), .tc(tc_b)
  );

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .up_down(up_down),
`ifdef BCD_CNT_TICK_EN
    .tick(tick),
`endif
    .count(cnt_c), .running(run_c), .tc(tc_c)
  );

  // ---------------- reference model (decimal integers) ----------------
  int nd [3] = '{2, 2, 4};
  bit wr [3] = '{1'b1, 1'b0, 1'b1};
  int mval [3];
  int mst  [3];   // 0 idle, 1 run, 2 paused
  bit mtc  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit tick_random = 1'b0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic int load_value(input logic [15:0] lv, input int n);
    int v = 0;
    for (int d = 0; d < n; d++) begin
      int nib = int'((lv >> (4 * d)) & 16'h000F);
      if (nib > 9) nib = 9;
      v = v + nib * pow10(d);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int n);
    logic [15:0] r = '0;
    int x = v;
    for (int d = 0; d < n; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mval[i] = 0; mst[i] = 0; mtc[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit te = HAS_TICK ? tick : 1'b1;
    for (int i = 0; i < 3; i++) begin
      int maxv = pow10(nd[i]) - 1;
      mtc[i] = 1'b0;
      if (clr) begin
        mval[i] = up_down ? 0 : maxv;
        mst[i]  = 0;
      end else if (load) begin
        mval[i] = load_value(load_val, nd[i]);
        mst[i]  = 0;
      end else if (stop) begin
        if (mst[i] == 1) mst[i] = 2;
      end else if (start && mst[i] != 1) begin
        mst[i] = 1;
      end else if (mst[i] == 1 && te) begin
        int term = up_down ? maxv : 0;
        if (mval[i] == term) begin
          mtc[i] = 1'b1;
          if (wr[i]) mval[i] = up_down ? 0 : maxv;
          else       mst[i]  = 0;
        end else begin
          mval[i] = up_down ? mval[i] + 1 : mval[i] - 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count_a", {8'h00, cnt_a}, to_bcd(mval[0], 2));
    check("count_b", {8'h00, cnt_b}, to_bcd(mval[1], 2));
    check("count_c", cnt_c, to_bcd(mval[2], 4));
    check("running_a", {15'd0, run_a}, {15'd0, mst[0] == 1});
    check("running_b", {15'd0, run_b}, {15'd0, mst[1] == 1});
    check("running_c", {15'd0, run_c}, {15'd0, mst[2] == 1});
    check("tc_a", {15'd0, tc_a}, {15'd0, mtc[0]});
    check("tc_b", {15'd0, tc_b}, {15'd0, mtc[1]});
    check("tc_c", {15'd0, tc_c}, {15'd0, mtc[2]});
  endtask

  // One clock: set tick, advance model with current inputs, sample #1 after edge.
  task automatic cycle();
    tick = tick_random ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
    cyc++;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    $display("t=%0t clr=%b ld=%b st=%b sp=%b ud=%b tk=%b | A=%h/%b/%b B=%h/%b/%b C=%h/%b/%b",
             $time, clr, load, start, stop, up_down, tick,
             cnt_a, run_a, tc_a, cnt_b, run_b, tc_b, cnt_c, run_c, tc_c);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    up_down = 1'b1; tick = 1'b0; load_val = '0;
    model_reset();
    #3;
    check_all();                       // reset state
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: load 97, count up with wrap
    load_val = 16'h0097; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; up_down = 1'b1; cycle(); start = 1'b0;
    repeat (12) cycle();

    // 2: load 02, count down; B saturates at 00
    load_val = 16'h0002; load = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; up_down = 1'b0; cycle(); start = 1'b0;
    repeat (12) cycle();

    // 3: run to 15, pause, resume
    load_val = 16'h0010; load = 1'b1; up_down = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int n = 0; n < 60 && mval[0] != 15; n++) cycle();
    check("reach_15", to_bcd(mval[0], 2), 16'h0015);
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (5) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();

    // 4: clr wins over everything; then clamped load
    clr = 1'b1; load = 1'b1; load_val = 16'h0042; stop = 1'b1; start = 1'b1; up_down = 1'b0;
    cycle();
    clr = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
    check("clr_wins_count", {8'h00, cnt_a}, 16'h0099);
    check("clr_wins_running", {15'd0, run_a}, 16'd0);
    load_val = 16'h00AF; load = 1'b1; cycle(); load = 1'b0;
    check("clamp_load", {8'h00, cnt_a}, 16'h0099);

    // 5: async reset mid-cycle while running at 37
    load_val = 16'h0030; load = 1'b1; up_down = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int n = 0; n < 60 && mval[0] != 37; n++) cycle();
    check("reach_37", to_bcd(mval[0], 2), 16'h0037);
    #3; rst = 1'b0;
    model_reset();
    #1; check_all();                   // no clock edge has occurred
    #2; rst = 1'b1;
    model_edge();
    @(posedge clk); #1; check_all();
    repeat (4) cycle();                // no start: must stay at 0

    // 6: 0999 -> 1000 on C
    load_val = 16'h0999; load = 1'b1; up_down = 1'b1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (12) cycle();

    // Random phase
    tick_random = 1'b1;
    for (int n = 0; n < 400; n++) begin
      clr      = ($urandom_range(0, 24) == 0);
      load     = ($urandom_range(0, 14) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      start    = ($urandom_range(0, 3) == 0);
      load_val = 16'($urandom);
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      cycle();
    end
    clr = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD up/down counter with a run/pause control FSM, parallel load, synchronous clear and terminal-count signalling. It generalises the team's fixed 2-digit decimal counter to DIGITS decades, adds a wrap or saturate mode, and accepts an arbitrary load value. It feeds the 7-segment display path, one nibble per digit.

Parameters:
DIGITS, 2, number of BCD decades; count width is 4*DIGITS.
WRAP, 1, 1 = wrap at terminal count and keep running; 0 = saturate at terminal count and return to IDLE.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
clr  input  1  synchronous clear.
load  input  1  synchronous parallel load.
load_val  input  4*DIGITS  BCD value to load.
start  input  1  enter or resume RUN.
stop  input  1  pause counting.
up_down  input  1  direction: 1 = up, 0 = down.
count  output  4*DIGITS  current BCD count; digit 0 in [3:0].
running  output  1  high while the FSM is in RUN.
tc  output  1  one-cycle pulse on a terminal-count event.

Behaviour:
- Reset (rst low, async): count = 0, FSM = IDLE, running = 0, tc = 0. Reset may assert mid-count; no partial update survives.
- FSM states:
  - IDLE: never counted, or finished.
  - RUN: counting.
  - PAUSED: stopped, count held.
- Control priority per edge: clr > load > stop > start > count step.
- clr: count = 0 if up_down = 1, else all digits 9. FSM goes to IDLE.
- load: count = load_val. Any nibble > 9 is clamped to 9 per digit. FSM goes to IDLE.
- stop: RUN goes to PAUSED. In IDLE or PAUSED, stop has no effect.
- start: IDLE or PAUSED goes to RUN. start in RUN has no effect. If start and stop are both high, stop wins.
- Start latency: start sampled at edge k puts the FSM in RUN and sets running = 1 after edge k. The first count step happens at edge k+1.
- Count step (RUN only, one step per cycle):
  - Up: BCD +1 with decimal ripple carry across digits (digit 9 goes to 0 and carries).
  - Down: BCD -1 with decimal borrow (digit 0 goes to 9 and borrows).
  - A new up_down value takes effect at the next step; there is no pipeline delay.
- Terminal count: all-9 when counting up, all-0 when counting down.
- A step from terminal with WRAP = 1:
  - count wraps (up: all-9 to 0; down: 0 to all-9); FSM stays in RUN.
  - tc = 1 for exactly the cycle after that edge.
- With WRAP = 0, at the step where count would leave terminal:
  - count holds at terminal and the FSM goes to IDLE (running falls).
  - tc pulses for one cycle.
- tc is registered and is 0 in every other cycle. clr and load never assert tc.
- count is always valid BCD after the first edge.

Optional Feature:
Macro: BCD_CNT_TICK_EN.
- Defined: adds input port tick (1 bit). A count step occurs only in cycles where RUN and tick = 1, which allows a prescaled rate. Control inputs remain per-cycle.
- Undefined: no tick port. The counter steps every cycle in RUN.

Decomposition:
- Shared package bcd_pkg holds:
  - FSM state typedef (IDLE, RUN, PAUSED);
  - BCD_MAX_DIGIT = 4'd9;
  - a per-digit clamp function.
- Sub-module bcd_digit: a single decade with inc, dec and carry/borrow in, next digit and carry/borrow out. It is instantiated DIGITS times in a generate loop; the top level holds the FSM and tc logic.

Test Plan:
1. Reset, load_val = 8'h97, load; start, up_down = 1, WRAP = 1 → count 97, 98, 99, 00, 01; tc high only in the cycle count = 00; running stays 1.
2. WRAP = 0, load 8'h02, start, up_down = 0 → count 01, 00, then holds 00; tc pulses once; running = 0 from that cycle.
3. Start, run to 8'h15, assert stop for 1 cycle, idle 5 cycles, start → count holds 15 throughout PAUSED; the next step after the resume latency gives 16.
4. Assert clr, load (load_val = 8'h42), stop and start together with up_down = 0 → clr wins: count = 99, FSM in IDLE, running = 0. Then load_val = 8'hAF with load → count = 99 (clamped).
5. Drop rst asynchronously mid-cycle while in RUN at count 8'h37 → count = 0, running = 0, tc = 0 immediately without a clock edge. After release, no stepping occurs until start.
6. DIGITS = 4, BCD_CNT_TICK_EN defined, tick every 3rd cycle, load 16'h0999, start, up → the step gives 1000 only on a tick cycle; count is unchanged on non-tick cycles.
